// File: rtl/tic_tac_toe_board.sv
// Tic-tac-toe board datapath: 3x3 grid storage, move legality check,
// win and board-full detection fed back to the turn controller.
module tic_tac_toe_board (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        play,
    input  logic [3:0]  pos,
    input  logic        playX_en,
    input  logic        play0_en,
    output logic        ill,
    output logic [1:0]  win,
    output logic        nospc,
    output logic [17:0] board,
    output logic [3:0]  move_cnt
);

    localparam logic [1:0] CellEmpty = 2'b00;
    localparam logic [1:0] CellX     = 2'b01;
    localparam logic [1:0] CellO     = 2'b10;
    localparam logic [3:0] CntFull   = 4'd9;

    logic [8:0][1:0] cell_q, cell_d;
    logic [3:0]      move_cnt_q, move_cnt_d;

    logic            x_line, o_line;
    logic [1:0]      target;
    logic            one_en, pos_bad, commit;

    // True when cells a, b and c all hold value v.
    function automatic logic line_hit(input logic [8:0][1:0] cells, input int a, input int b,
                                      input int c, input logic [1:0] v);
        return (cells[a] == v) && (cells[b] == v) && (cells[c] == v);
    endfunction

    // Owner of any completed line among the eight rows, columns and diagonals.
    always_comb begin
        x_line = 1'b0;
        o_line = 1'b0;
        for (int k = 0; k < 2; k++) begin
            logic       hit;
            logic [1:0] v;
            v   = (k == 0) ? CellX : CellO;
            hit = line_hit(cell_q, 0, 1, 2, v) | line_hit(cell_q, 3, 4, 5, v) |
                  line_hit(cell_q, 6, 7, 8, v) | line_hit(cell_q, 0, 3, 6, v) |
                  line_hit(cell_q, 1, 4, 7, v) | line_hit(cell_q, 2, 5, 8, v) |
                  line_hit(cell_q, 0, 4, 8, v) | line_hit(cell_q, 2, 4, 6, v);
            if (k == 0) x_line = hit;
            else        o_line = hit;
        end
    end

    // Legality of the current attempt; pos beyond 8 reads as an empty target
    // but is rejected separately by pos_bad.
    always_comb begin
        target = CellEmpty;
        for (int k = 0; k < 9; k++) begin
            if (pos == 4'(k)) target = cell_q[k];
        end
        one_en  = playX_en ^ play0_en;
        pos_bad = (pos > 4'd8);
        ill     = play & (~one_en | pos_bad | (target != CellEmpty) | (win != 2'b00));
        commit  = play & ~ill;
    end

    // Next board state: clear wins over a commit in the same cycle.
    always_comb begin
        cell_d     = cell_q;
        move_cnt_d = move_cnt_q;
        if (clr) begin
            cell_d     = '0;
            move_cnt_d = '0;
        end else if (commit) begin
            for (int k = 0; k < 9; k++) begin
                if (pos == 4'(k)) cell_d[k] = playX_en ? CellX : CellO;
            end
            move_cnt_d = (move_cnt_q == CntFull) ? CntFull : move_cnt_q + 4'd1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cell_q     <= '0;
            move_cnt_q <= '0;
        end else begin
            cell_q     <= cell_d;
            move_cnt_q <= move_cnt_d;
        end
    end

    assign win      = x_line ? 2'b01 : (o_line ? 2'b10 : 2'b00);
    assign nospc    = (move_cnt_q == CntFull);
    assign board    = cell_q;
    assign move_cnt = move_cnt_q;

endmodule

// File: tb/tb_tic_tac_toe_board.sv
// Scoreboard bench for tic_tac_toe_board: directed games plus random play,
// checked against a grid-level reference model of the game rules.
module tb_tic_tac_toe_board;

    logic        clk = 1'b0;
    logic        rst, clr, play, playX_en, play0_en;
    logic [3:0]  pos;
    logic        ill, nospc;
    logic [1:0]  win;
    logic [17:0] board;
    logic [3:0]  move_cnt;

    tic_tac_toe_board dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .play     (play),
        .pos      (pos),
        .playX_en (playX_en),
        .play0_en (play0_en),
        .ill      (ill),
        .win      (win),
        .nospc    (nospc),
        .board    (board),
        .move_cnt (move_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic        ill;
        logic [17:0] board;
        logic [3:0]  cnt;
        logic [1:0]  win;
        logic        nospc;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cycle  = 0;

    // Reference model: 0 empty, 1 X, 2 O.
    int grid[9];
    int moves;
    bit known = 1'b0;
    int lines[8][3] = '{'{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8}, '{0, 3, 6},
                        '{1, 4, 7}, '{2, 5, 8}, '{0, 4, 8}, '{2, 4, 6}};

    function automatic int winner();
        for (int l = 0; l < 8; l++) begin
            int a, b, c;
            a = lines[l][0]; b = lines[l][1]; c = lines[l][2];
            if (grid[a] != 0 && grid[a] == grid[b] && grid[b] == grid[c]) return grid[a];
        end
        return 0;
    endfunction

    function automatic logic [17:0] packed_grid();
        logic [17:0] b;
        b = '0;
        for (int k = 0; k < 9; k++) b[2*k +: 2] = 2'(grid[k]);
        return b;
    endfunction

    function automatic void wipe();
        for (int k = 0; k < 9; k++) grid[k] = 0;
        moves = 0;
    endfunction

    // One clock cycle of stimulus; records what the DUT must show this cycle
    // and then advances the model across the coming edge.
    task automatic step(input bit r, input bit c, input bit p, input int ps,
                        input bit xe, input bit oe);
        bit e_ill;
        int w;
        @(posedge clk);
        #1;
        cycle++;
        rst = r; clr = c; play = p; pos = 4'(ps); playX_en = xe; play0_en = oe;
        w = known ? winner() : 0;
        e_ill = p && ((xe == oe) || ps > 8 || (ps <= 8 && grid[ps] != 0) || w != 0);
        if (known) begin
            exp_t e;
            e.cyc = cycle; e.ill = e_ill; e.board = packed_grid(); e.cnt = 4'(moves);
            e.win = (w == 1) ? 2'b01 : ((w == 2) ? 2'b10 : 2'b00);
            e.nospc = (moves == 9);
            exp_q.push_back(e);
        end
        if (!r) begin
            wipe();
            known = 1'b1;
        end else if (known) begin
            if (c) wipe();
            else if (p && !e_ill) begin
                grid[ps] = xe ? 1 : 2;
                if (moves < 9) moves++;
            end
        end
    endtask

    task automatic mv_x(input int ps); step(1, 0, 1, ps, 1, 0); endtask
    task automatic mv_o(input int ps); step(1, 0, 1, ps, 0, 1); endtask
    task automatic idle();             step(1, 0, 0, 0, 0, 0);  endtask
    task automatic new_game();         step(1, 1, 0, 0, 0, 0);  endtask

    task automatic check(input string name, input int cyc, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    // Monitor: the DUT presents a full output set every cycle; compare mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("ill", e.cyc, 32'(ill), 32'(e.ill));
            check("board", e.cyc, 32'(board), 32'(e.board));
            check("move_cnt", e.cyc, 32'(move_cnt), 32'(e.cnt));
            check("win", e.cyc, 32'(win), 32'(e.win));
            check("nospc", e.cyc, 32'(nospc), 32'(e.nospc));
        end
    end

    initial begin
        int turn;
        rst = 1'b0; clr = 1'b0; play = 1'b0; pos = '0; playX_en = 1'b0; play0_en = 1'b0;

        // Reset held two cycles with a legal-looking move present.
        step(0, 0, 1, 4, 1, 0);
        step(0, 0, 1, 4, 1, 0);
        idle();

        // Single move, occupied cell, out of range, repeated pos.
        mv_x(4); mv_o(4); idle(); mv_o(9); mv_x(3); mv_o(3); idle();

        // Row win for X, then a frozen board.
        new_game();
        mv_x(0); mv_o(3); mv_x(1); mv_o(4); mv_x(2); mv_o(5); idle();

        // Diagonal win for O.
        new_game();
        mv_x(0); mv_o(2); mv_x(1); mv_o(4); mv_x(8); mv_o(6); mv_x(5); idle();

        // Draw on a full board, then a further attempt.
        new_game();
        mv_x(0); mv_o(1); mv_x(2); mv_o(4); mv_x(3); mv_o(6); mv_x(7); mv_o(8); mv_x(5);
        idle(); mv_o(0); idle();

        // Win completed by the ninth move.
        new_game();
        mv_x(4); mv_o(1); mv_x(0); mv_o(5); mv_x(2); mv_o(6); mv_x(3); mv_o(7); mv_x(8);
        idle();

        // Clear beats a simultaneous legal move; both enables; no enable.
        step(1, 1, 1, 4, 1, 0);
        step(1, 1, 1, 3, 0, 1);
        idle();
        step(1, 0, 1, 4, 1, 1);
        step(1, 0, 1, 4, 0, 0);
        mv_x(4);
        step(0, 0, 1, 5, 0, 1);
        idle();

        // Random play with occasional clears and resets.
        turn = 0;
        for (int i = 0; i < 1500; i++) begin
            bit r, c, p, xe, oe;
            int sel;
            r   = ($urandom_range(0, 99) != 0);
            c   = ($urandom_range(0, 29) == 0) ||
                  ((winner() != 0 || moves == 9) && $urandom_range(0, 3) == 0);
            p   = ($urandom_range(0, 3) != 0);
            sel = $urandom_range(0, 9);
            if (sel == 0)      begin xe = 1; oe = 1; end
            else if (sel == 1) begin xe = 0; oe = 0; end
            else               begin xe = (turn == 0); oe = (turn == 1); end
            step(r, c, p, $urandom_range(0, 10), xe, oe);
            turn ^= 1;
        end

        idle(); idle();
        @(negedge clk);
        #1;
        check("queue_drained", cycle, 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
